step_clk_gen: RTL

- Produces the CPU step clock from a raw push button (single-step) or from a free-running divider (auto-run).
- Sits directly upstream of the CPU's clk input on the board top level.
- Debounces the button, emits exactly one clean step per accepted press, and counts steps so the display mux can show progress.

---
 rtl/step_clk_gen_pkg.sv | 13 +
 rtl/step_clk_gen_if.sv | 21 ++
 rtl/step_clk_gen_key_debounce.sv | 87 ++++++++
 rtl/step_clk_gen.sv | 102 ++++++++++
 4 files changed

// File: rtl/step_clk_gen_pkg.sv
// Shared types and constants for the CPU step-clock generator.
package step_clk_gen_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_WAIT_PRESS   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_WAIT_RELEASE = 2'd3
    } db_state_e;

endpackage

// File: rtl/step_clk_gen_if.sv
// Button/switch inputs and step-clock outputs of the step clock generator.
interface step_clk_gen_if #(
    parameter int unsigned CNT_W = 16
);
    logic             btn_step;
    logic             sw_run;
    logic             step_clk;
    logic             step_pulse;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;

    modport master (
        output btn_step, sw_run,
        input  step_clk, step_pulse, step_cnt, busy
    );

    modport slave (
        input  btn_step, sw_run,
        output step_clk, step_pulse, step_cnt, busy
    );
endinterface

// File: rtl/step_clk_gen_key_debounce.sv
// Synchronises a raw key and emits a one-cycle press strobe once the key has
// been stably down for DB_CYCLES samples; release needs the same stability.
module step_clk_gen_key_debounce
    import step_clk_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  key_s;
    db_state_e             state_q, state_d;
    logic [DB_W-1:0]       cnt_q, cnt_d;
    logic                  press_q, press_d;

    assign key_s = sync_q[SYNC_DEPTH-1];
    assign press = press_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], key};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Counter holds the number of consecutive samples seen in the new level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (key_s) begin
                    state_d = DB_WAIT_PRESS;
                    cnt_d   = DB_W'(1);
                end
            end
            DB_WAIT_PRESS: begin
                if (!key_s) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_W'(DB_CYCLES - 1)) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            DB_PRESSED: begin
                if (!key_s) begin
                    state_d = DB_WAIT_RELEASE;
                    cnt_d   = DB_W'(1);
                end
            end
            DB_WAIT_RELEASE: begin
                if (key_s) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_W'(DB_CYCLES - 1)) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/step_clk_gen.sv
// CPU step clock: one clean high/low window per debounced press, or one per
// RUN_DIV cycles in auto-run, with a one-deep pending slot and a step counter.
module step_clk_gen
    import step_clk_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 1_000_000,
    parameter int unsigned RUN_DIV     = 50_000_000,
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    step_clk_gen_if.slave  bus
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int unsigned WIN_W = (2 * HIGH_CYCLES > 1) ? $clog2(2 * HIGH_CYCLES) : 1;

    logic [SYNC_DEPTH-1:0] run_sync_q;
    logic                  run_s;
    logic                  press;
    logic [DIV_W-1:0]      div_q;
    logic                  run_req_c;
    logic                  req_c;

    logic                  step_clk_q;
    logic                  step_pulse_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  pend_q;
    logic [WIN_W-1:0]      win_q;

    step_clk_gen_key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .rst   (rst),
        .key   (bus.btn_step),
        .press (press)
    );

    assign run_s     = run_sync_q[SYNC_DEPTH-1];
    assign run_req_c = run_s && (div_q == DIV_W'(RUN_DIV - 1));
    assign req_c     = run_s ? run_req_c : press;

    // Run-mode divider; parked at 0 whenever auto-run is off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync_q <= '0;
            div_q      <= '0;
        end else begin
            run_sync_q <= {run_sync_q[SYNC_DEPTH-2:0], bus.sw_run};
            if (!run_s || run_req_c) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // Window: HIGH_CYCLES high then HIGH_CYCLES low, busy across both halves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_clk_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            win_q        <= '0;
        end else begin
            step_pulse_q <= 1'b0;
            if (!busy_q) begin
                if (req_c || pend_q) begin
                    step_clk_q   <= 1'b1;
                    step_pulse_q <= 1'b1;
                    busy_q       <= 1'b1;
                    win_q        <= '0;
                    cnt_q        <= cnt_q + CNT_W'(1);
                    // A fresh request landing while pending is served refills the slot.
                    pend_q       <= pend_q & req_c;
                end
            end else begin
                if (req_c) begin
                    pend_q <= 1'b1;
                end
                win_q <= win_q + WIN_W'(1);
                if (win_q == WIN_W'(HIGH_CYCLES - 1)) begin
                    step_clk_q <= 1'b0;
                end
                if (win_q == WIN_W'(2 * HIGH_CYCLES - 1)) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.step_clk   = step_clk_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.step_cnt   = cnt_q;
    assign bus.busy       = busy_q;

endmodule
